// File: rtl/ahb_apb_bridge_pkg.sv
// ----------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the AHB-Lite to APB bridge:
//   - state_t      : bridge FSM state encoding
//   - HTRANS_*     : AHB transfer-type codes
//   - PERIPHx_BASE : APB peripheral address windows (64 MiB each)
//   - decode_sel() : address to one-hot peripheral select
// ----------------------------------------------------------------------------
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [31:0] PERIPH0_BASE = 32'h8000_0000;
    localparam logic [31:0] PERIPH1_BASE = 32'h8400_0000;
    localparam logic [31:0] PERIPH2_BASE = 32'h8800_0000;
    localparam logic [31:0] MAP_LIMIT    = 32'h8C00_0000;

    // Returns 3'b000 for any address outside the bridge window; callers use
    // that as the "not ours" indication.
    function automatic logic [2:0] decode_sel(input logic [31:0] addr);
        logic [2:0] sel;
        sel = 3'b000;
        if (addr >= PERIPH0_BASE && addr < PERIPH1_BASE) begin
            sel = 3'b001;
        end else if (addr >= PERIPH1_BASE && addr < PERIPH2_BASE) begin
            sel = 3'b010;
        end else if (addr >= PERIPH2_BASE && addr < MAP_LIMIT) begin
            sel = 3'b100;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ahb_apb_bridge_if.sv
// ----------------------------------------------------------------------------
// ahb_apb_bridge_if
// Bus bundle around the bridge: AHB-Lite slave side and APB master side.
//   slave  : the bridge's view (AHB request + prdata in, responses + APB out)
//   master : the environment's view (drives AHB, supplies prdata, observes)
// ----------------------------------------------------------------------------
interface ahb_apb_bridge_if;

    // AHB side
    logic        hwrite;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [31:0] hrdata;
    logic [1:0]  hresp;

    // APB side
    logic [31:0] prdata;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    modport slave (
        input  hwrite, hreadyin, htrans, haddr, hwdata, prdata,
        output hreadyout, hrdata, hresp, pselx, penable, pwrite, paddr, pwdata
    );

    modport master (
        output hwrite, hreadyin, htrans, haddr, hwdata, prdata,
        input  hreadyout, hrdata, hresp, pselx, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/ahb_apb_bridge_ahb_slave_if.sv
// ----------------------------------------------------------------------------
// ahb_slave_if
// AHB front end of the bridge: transfer qualification, peripheral decode and
// the address/data/control pipeline the FSM draws on.
//   hclk, hresetn        : clock, async active-low reset
//   hwrite .. hwdata     : raw AHB inputs
//   valid                : a real transfer into the bridge window this cycle
//   tempselx             : one-hot select decoded from the current haddr
//   haddr1/haddr2        : haddr delayed by one / two cycles
//   hwrite_reg           : hwrite delayed by one cycle
//   selx1/selx2          : tempselx delayed by one / two cycles
// ----------------------------------------------------------------------------
module ahb_slave_if
    import bridge_pkg::*;
(
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hwrite,
    input  logic        hreadyin,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    output logic        valid,
    output logic [2:0]  tempselx,
    output logic [31:0] haddr1,
    output logic [31:0] haddr2,
    output logic        hwrite_reg,
    output logic [2:0]  selx1,
    output logic [2:0]  selx2
);

    // Write data delayed by one cycle; kept alongside the address pipeline.
    logic [31:0] hwdata1;

    assign tempselx = decode_sel(haddr);

    // An out-of-window address decodes to 000, which also kills valid.
    assign valid = hreadyin
                && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)
                && (tempselx != 3'b000);

    // NOTE: registers use non-blocking assignments so every stage samples the
    // pre-edge value of the stage before it; blocking here would collapse
    // haddr1/haddr2 into a single stage.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            haddr1     <= '0;
            haddr2     <= '0;
            hwdata1    <= '0;
            hwrite_reg <= 1'b0;
            selx1      <= '0;
            selx2      <= '0;
        end else begin
            haddr1     <= haddr;
            haddr2     <= haddr1;
            hwdata1    <= hwdata;
            hwrite_reg <= hwrite;
            selx1      <= tempselx;
            selx2      <= selx1;
        end
    end

endmodule

// File: rtl/ahb_apb_bridge.sv
// ----------------------------------------------------------------------------
// ahb_apb_bridge
// AHB-Lite slave to APB master bridge for three peripherals. Single reads,
// single writes and pipelined burst writes are replayed as APB setup/enable
// pairs; hreadyout stalls the master during each setup cycle.
//   hclk    : clock, rising edge
//   hresetn : async active-low reset
//   bus     : AHB request/response and APB master signals (slave modport)
// ----------------------------------------------------------------------------
module ahb_apb_bridge
    import bridge_pkg::*;
(
    input  logic             hclk,
    input  logic             hresetn,
    ahb_apb_bridge_if.slave  bus
);

    logic        valid;
    logic [2:0]  tempselx;
    logic [31:0] haddr1;
    logic [31:0] haddr2;
    logic        hwrite_reg;
    logic [2:0]  selx1;
    logic [2:0]  selx2;

    state_t      state;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hreadyout;

    ahb_slave_if u_ahb_slave_if (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .hwrite     (bus.hwrite),
        .hreadyin   (bus.hreadyin),
        .htrans     (bus.htrans),
        .haddr      (bus.haddr),
        .hwdata     (bus.hwdata),
        .valid      (valid),
        .tempselx   (tempselx),
        .haddr1     (haddr1),
        .haddr2     (haddr2),
        .hwrite_reg (hwrite_reg),
        .selx1      (selx1),
        .selx2      (selx2)
    );

    // Outputs are loaded on the edge that enters each state, so the APB
    // signals seen in a state are exactly that state's setup/enable values.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= ST_IDLE;
            pselx     <= '0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            hreadyout <= 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                    if (valid && !bus.hwrite) begin
                        // Read address is still on the bus: use it directly.
                        state     <= ST_READ;
                        paddr     <= bus.haddr;
                        pselx     <= tempselx;
                        pwrite    <= 1'b0;
                        penable   <= 1'b0;
                        hreadyout <= 1'b0;
                    end else begin
                        // Write first waits a cycle for its data; otherwise idle.
                        state     <= valid ? ST_WWAIT : ST_IDLE;
                        pselx     <= '0;
                        penable   <= 1'b0;
                        hreadyout <= 1'b1;
                    end
                end

                ST_WWAIT: begin
                    // hwdata now belongs to the address captured last cycle.
                    state     <= valid ? ST_WRITEP : ST_WRITE;
                    paddr     <= haddr1;
                    pwdata    <= bus.hwdata;
                    pselx     <= selx1;
                    pwrite    <= 1'b1;
                    penable   <= 1'b0;
                    hreadyout <= 1'b0;
                end

                ST_READ: begin
                    state     <= ST_RENABLE;
                    penable   <= 1'b1;
                    hreadyout <= 1'b1;
                end

                ST_WRITE: begin
                    state     <= valid ? ST_WENABLEP : ST_WENABLE;
                    penable   <= 1'b1;
                    hreadyout <= 1'b1;
                end

                ST_WRITEP: begin
                    state     <= ST_WENABLEP;
                    penable   <= 1'b1;
                    hreadyout <= 1'b1;
                end

                ST_WENABLEP: begin
                    if (!hwrite_reg) begin
                        state     <= ST_READ;
                        paddr     <= bus.haddr;
                        pselx     <= tempselx;
                        pwrite    <= 1'b0;
                        penable   <= 1'b0;
                        hreadyout <= 1'b0;
                    end else begin
                        // The stall in WRITEP pushes the pending beat's address
                        // two stages back in the pipeline.
                        state     <= valid ? ST_WRITEP : ST_WRITE;
                        paddr     <= haddr2;
                        pwdata    <= bus.hwdata;
                        pselx     <= selx2;
                        pwrite    <= 1'b1;
                        penable   <= 1'b0;
                        hreadyout <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pselx     = pselx;
    assign bus.penable   = penable;
    assign bus.pwrite    = pwrite;
    assign bus.paddr     = paddr;
    assign bus.pwdata    = pwdata;
    assign bus.hreadyout = hreadyout;
    assign bus.hrdata    = bus.prdata;
    assign bus.hresp     = 2'b00;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// ----------------------------------------------------------------------------
// tb_ahb_apb_bridge
// Directed bench for ahb_apb_bridge: reset values, single write/read, decode
// windows and rejected transfers, a 4-beat burst write logged by an APB
// monitor, and reset asserted in the middle of a burst.
// ----------------------------------------------------------------------------
module tb_ahb_apb_bridge;
    import bridge_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  sel;
    } apb_rec_t;

    logic hclk;
    logic hresetn;
    int   total = 0;
    int   bad   = 0;

    ahb_apb_bridge_if bif ();

    ahb_apb_bridge dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bif)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic [1:0] trans, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
        bif.htrans   = trans;
        bif.hwrite   = wr;
        bif.haddr    = addr;
        bif.hwdata   = data;
        bif.hreadyin = 1'b1;
    endtask

    // ---------------- APB monitor: logs enable phases, checks setup->enable
    apb_rec_t    apb_log[$];
    logic        rec_on = 1'b0;
    int          viol = 0;
    logic        prev_penable = 1'b0;
    logic [2:0]  prev_sel = '0;
    logic [31:0] prev_addr = '0;

    initial begin
        forever begin
            @(posedge hclk);
            #1;
            if (bif.penable) begin
                if (prev_penable || prev_sel != bif.pselx || prev_addr != bif.paddr
                    || bif.pselx == 3'b000) begin
                    viol++;
                end
                if (rec_on && bif.pwrite) begin
                    apb_rec_t r;
                    r.addr = bif.paddr;
                    r.data = bif.pwdata;
                    r.sel  = bif.pselx;
                    apb_log.push_back(r);
                end
            end
            prev_penable = bif.penable;
            prev_sel     = bif.pselx;
            prev_addr    = bif.paddr;
        end
    end

    // ---------------- transaction tasks with per-cycle expectations
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] sel);
        drive(HTRANS_NONSEQ, 1'b1, addr, 32'h0);
        step();
        check({tag, "_wwait_st"}, 32'(dut.state), 32'(ST_WWAIT));
        check({tag, "_wwait_rdy"}, 32'(bif.hreadyout), 32'd1);
        check({tag, "_wwait_sel"}, 32'(bif.pselx), 32'd0);
        drive(HTRANS_IDLE, 1'b1, 32'h0, data);
        step();
        check({tag, "_setup_st"}, 32'(dut.state), 32'(ST_WRITE));
        check({tag, "_setup_sel"}, 32'(bif.pselx), 32'(sel));
        check({tag, "_setup_pwrite"}, 32'(bif.pwrite), 32'd1);
        check({tag, "_setup_paddr"}, bif.paddr, addr);
        check({tag, "_setup_pwdata"}, bif.pwdata, data);
        check({tag, "_setup_pen"}, 32'(bif.penable), 32'd0);
        check({tag, "_setup_rdy"}, 32'(bif.hreadyout), 32'd0);
        drive(HTRANS_IDLE, 1'b1, 32'h0, 32'h0);
        step();
        check({tag, "_en_st"}, 32'(dut.state), 32'(ST_WENABLE));
        check({tag, "_en_pen"}, 32'(bif.penable), 32'd1);
        check({tag, "_en_paddr"}, bif.paddr, addr);
        check({tag, "_en_sel"}, 32'(bif.pselx), 32'(sel));
        check({tag, "_en_rdy"}, 32'(bif.hreadyout), 32'd1);
        step();
        check({tag, "_done_st"}, 32'(dut.state), 32'(ST_IDLE));
        check({tag, "_done_sel"}, 32'(bif.pselx), 32'd0);
        check({tag, "_done_pen"}, 32'(bif.penable), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [2:0] sel);
        drive(HTRANS_NONSEQ, 1'b0, addr, 32'h0);
        bif.prdata = rdata;
        step();
        check({tag, "_setup_st"}, 32'(dut.state), 32'(ST_READ));
        check({tag, "_setup_sel"}, 32'(bif.pselx), 32'(sel));
        check({tag, "_setup_paddr"}, bif.paddr, addr);
        check({tag, "_setup_pwrite"}, 32'(bif.pwrite), 32'd0);
        check({tag, "_setup_pen"}, 32'(bif.penable), 32'd0);
        check({tag, "_setup_rdy"}, 32'(bif.hreadyout), 32'd0);
        drive(HTRANS_IDLE, 1'b0, 32'h0, 32'h0);
        step();
        check({tag, "_en_st"}, 32'(dut.state), 32'(ST_RENABLE));
        check({tag, "_en_pen"}, 32'(bif.penable), 32'd1);
        check({tag, "_en_hrdata"}, bif.hrdata, rdata);
        check({tag, "_en_rdy"}, 32'(bif.hreadyout), 32'd1);
        step();
        check({tag, "_done_st"}, 32'(dut.state), 32'(ST_IDLE));
    endtask

    // A transfer that must not start anything on APB.
    task automatic no_start(input string tag, input logic [1:0] trans, input logic ready,
                            input logic [31:0] addr);
        drive(trans, 1'b1, addr, 32'h0);
        bif.hreadyin = ready;
        step();
        check({tag, "_st1"}, 32'(dut.state), 32'(ST_IDLE));
        check({tag, "_sel1"}, 32'(bif.pselx), 32'd0);
        drive(HTRANS_IDLE, 1'b1, 32'h0, 32'hDEAD_BEEF);
        step();
        check({tag, "_st2"}, 32'(dut.state), 32'(ST_IDLE));
        check({tag, "_pen2"}, 32'(bif.penable), 32'd0);
    endtask

    // AHB master honouring hreadyout: the address on the bus is accepted on an
    // edge where hreadyout was high, and its data is driven until the next one.
    task automatic run_burst(input logic [31:0] baddr[4], input logic [31:0] bdata[4]);
        int   ai  = 0;
        int   di  = -1;
        int   cyc = 0;
        logic rdy;
        while (di < 4 && cyc < 40) begin
            if (ai < 4) begin
                drive((ai == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, baddr[ai], 32'h0);
            end else begin
                drive(HTRANS_IDLE, 1'b1, 32'h0, 32'h0);
            end
            bif.hwdata = (di >= 0 && di < 4) ? bdata[di] : 32'h0;
            rdy = bif.hreadyout;
            step();
            cyc++;
            if (rdy) begin
                di = ai;
                ai++;
            end
        end
        check("burst_master_done", 32'(di >= 4), 32'd1);
        drive(HTRANS_IDLE, 1'b1, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (dut.state == ST_IDLE) break;
            step();
        end
        check("burst_drain_st", 32'(dut.state), 32'(ST_IDLE));
    endtask

    initial begin
        logic [31:0] baddr[4];
        logic [31:0] bdata[4];

        hresetn = 1'b0;
        drive(HTRANS_IDLE, 1'b1, 32'h0, 32'h0);
        bif.prdata = 32'h0;
        repeat (2) @(posedge hclk);
        #1;
        check("rst_st", 32'(dut.state), 32'(ST_IDLE));
        check("rst_sel", 32'(bif.pselx), 32'd0);
        check("rst_pen", 32'(bif.penable), 32'd0);
        check("rst_pwrite", 32'(bif.pwrite), 32'd0);
        check("rst_paddr", bif.paddr, 32'd0);
        check("rst_pwdata", bif.pwdata, 32'd0);
        check("rst_rdy", 32'(bif.hreadyout), 32'd1);
        check("rst_hresp", 32'(bif.hresp), 32'd0);
        @(negedge hclk);
        hresetn = 1'b1;
        step();

        // single transfers
        do_write("wr1", 32'h8000_0001, 32'h0000_0080, 3'b001);
        do_read("rd1", 32'h8000_0001, 32'h0000_005A, 3'b001);

        // decode windows and edges
        do_read("dec1", 32'h8400_0010, 32'h1111_2222, 3'b010);
        do_read("dec2", 32'h8800_0000, 32'h3333_4444, 3'b100);
        do_read("dec2_top", 32'h8BFF_FFFC, 32'h5555_6666, 3'b100);
        do_read("dec0_top", 32'h83FF_FFFF, 32'h7777_8888, 3'b001);

        // rejected transfers
        no_start("oor_9000", HTRANS_NONSEQ, 1'b1, 32'h9000_0000);
        no_start("oor_8c00", HTRANS_NONSEQ, 1'b1, 32'h8C00_0000);
        no_start("oor_7fff", HTRANS_SEQ, 1'b1, 32'h7FFF_FFFF);
        no_start("busy", HTRANS_BUSY, 1'b1, 32'h8000_0000);
        no_start("notready", HTRANS_NONSEQ, 1'b0, 32'h8400_0000);

        // 4-beat burst write
        for (int i = 0; i < 4; i++) begin
            baddr[i] = 32'h8000_0001 + 32'(i);
            bdata[i] = $urandom;
        end
        apb_log.delete();
        rec_on = 1'b1;
        run_burst(baddr, bdata);
        rec_on = 1'b0;
        check("burst_count", 32'(apb_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < apb_log.size(); i++) begin
            check($sformatf("burst%0d_addr", i), apb_log[i].addr, baddr[i]);
            check($sformatf("burst%0d_data", i), apb_log[i].data, bdata[i]);
            check($sformatf("burst%0d_sel", i), 32'(apb_log[i].sel), 32'd1);
        end

        // reset asserted while a burst sits in WENABLEP
        drive(HTRANS_NONSEQ, 1'b1, 32'h8000_0010, 32'h0);
        step();
        drive(HTRANS_SEQ, 1'b1, 32'h8000_0014, 32'h0000_0011);
        step();
        check("mid_writep_st", 32'(dut.state), 32'(ST_WRITEP));
        drive(HTRANS_SEQ, 1'b1, 32'h8000_0018, 32'h0000_0022);
        step();
        check("mid_wenablep_st", 32'(dut.state), 32'(ST_WENABLEP));
        check("mid_wenablep_pen", 32'(bif.penable), 32'd1);
        #2;
        hresetn = 1'b0;
        #1;
        check("mid_rst_st", 32'(dut.state), 32'(ST_IDLE));
        check("mid_rst_sel", 32'(bif.pselx), 32'd0);
        check("mid_rst_pen", 32'(bif.penable), 32'd0);
        check("mid_rst_pwrite", 32'(bif.pwrite), 32'd0);
        check("mid_rst_paddr", bif.paddr, 32'd0);
        check("mid_rst_pwdata", bif.pwdata, 32'd0);
        check("mid_rst_rdy", 32'(bif.hreadyout), 32'd1);
        drive(HTRANS_IDLE, 1'b1, 32'h0, 32'h0);
        @(negedge hclk);
        hresetn = 1'b1;
        step();
        check("post_rst_st", 32'(dut.state), 32'(ST_IDLE));
        check("post_rst_pen", 32'(bif.penable), 32'd0);
        do_write("wr_after_rst", 32'h8400_0008, 32'h1234_5678, 3'b010);

        check("penable_follows_setup", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

AHB-Lite slave to APB master bridge that consumes the transfers issued by the AHB master driver (`haddr`, `hwdata`, `hwrite`, `htrans`, `hreadyin`) and replays them as APB setup/enable cycles to one of three peripherals. It pipelines the AHB address and data phases, decodes the peripheral select, sequences transfers through an eight-state FSM, and returns read data and `hreadyout` to the master. It supports single reads, single writes and back-to-back (burst) writes.

## Interface

- Parameters: none. The address map and state encoding come from `bridge_pkg`.
- `hclk` in 1: sole clock, rising edge.
- `hresetn` in 1: asynchronous, active-low reset.
- `hwrite` in 1: 1 = write, 0 = read.
- `hreadyin` in 1: master ready qualifier.
- `htrans` in 2: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- `haddr` in 32: AHB address.
- `hwdata` in 32: AHB write data, valid one cycle after its address.
- `prdata` in 32: APB read data.
- `hreadyout` out 1: bridge ready to the master.
- `hrdata` out 32: read data to the master.
- `hresp` out 2: tied to 2'b00 (OKAY).
- `pselx` out 3: one-hot peripheral select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB direction.
- `paddr` out 32: APB address.
- `pwdata` out 32: APB write data.

## Operation

- `valid` = `hreadyin` & `htrans`∈{2,3} & 0x8000_0000 ≤ `haddr` < 0x8C00_0000.
- Address decode (`tempselx`):
  - 0x8000_0000–0x83FF_FFFF → 3'b001
  - 0x8400_0000–0x87FF_FFFF → 3'b010
  - 0x8800_0000–0x8BFF_FFFF → 3'b100
  - any other address → 3'b000, and `valid`=0
- Pipeline registers, updated every clock:
  - `haddr1`←`haddr`, `haddr2`←`haddr1`
  - `hwdata1`←`hwdata`
  - `hwrite_reg`←`hwrite`
  - `selx1`←`tempselx`, `selx2`←`selx1`
- FSM transitions:
  - IDLE: valid&hwrite→WWAIT; valid&!hwrite→READ; else stay in IDLE.
  - WWAIT: valid→WRITEP; else→WRITE.
  - READ: →RENABLE.
  - WRITE: valid→WENABLEP; else→WENABLE.
  - WRITEP: →WENABLEP.
  - RENABLE and WENABLE: valid&!hwrite→READ; valid&hwrite→WWAIT; else→IDLE.
  - WENABLEP: !hwrite_reg→READ; hwrite_reg&valid→WRITEP; hwrite_reg&!valid→WRITE.
- Output registers are loaded on the edge that enters each state:
  - Entering READ: `paddr`=`haddr`, `pselx`=`tempselx`, `pwrite`=0, `penable`=0, `hreadyout`=0.
  - Entering WRITE or WRITEP from WWAIT: `paddr`=`haddr1`, `pwdata`=`hwdata`, `pselx`=`selx1`, `pwrite`=1, `penable`=0, `hreadyout`=0.
  - Entering WRITE or WRITEP from WENABLEP: same as above, but using `haddr2` and `selx2`.
  - Entering RENABLE, WENABLE or WENABLEP: `penable`=1, `hreadyout`=1; `paddr`, `pwdata`, `pselx` and `pwrite` are held.
  - Entering IDLE or WWAIT: `pselx`=0, `penable`=0, `hreadyout`=1; `paddr` and `pwdata` are held.
- `hrdata` = `prdata` (combinational pass-through).

## Timing

- Reset (asynchronous assert, synchronous release):
  - state=IDLE
  - `pselx`=0, `penable`=0, `pwrite`=0
  - `paddr`=0, `pwdata`=0
  - `hreadyout`=1
  - all pipeline registers =0
- Single read: address edge T0 → READ at T1 (setup phase) → RENABLE at T2 (enable phase). `prdata` is sampled by the master at T2. Two-cycle APB transfer.
- Single write: address edge T0 → WWAIT at T1 (waiting for `hwdata`) → WRITE at T2 → WENABLE at T3. The APB write completes 3 cycles after the address.
- Burst write (pipelined): each beat passes through WRITEP→WENABLEP, giving one APB transfer per 2 cycles. The last beat exits through WRITE→WENABLE→IDLE.
- Out-of-range or IDLE/BUSY `htrans`: `valid`=0; no APB activity is started; the FSM holds IDLE or drains its current transfer.
- `penable` is only ever high the cycle after a setup cycle with the same `pselx`/`paddr`.
- Reset asserted mid-transfer: all outputs reach their reset values immediately; no partial transfer resumes after release.

## Structure

- `bridge_pkg` holds:
  - state enum: IDLE, WWAIT, READ, WRITE, WRITEP, RENABLE, WENABLE, WENABLEP
  - HTRANS constants
  - peripheral base/limit addresses
- Sub-module `ahb_slave_if` holds the pipeline registers, `valid` generation and `tempselx` decode.
- The top-level `ahb_apb_bridge` instantiates `ahb_slave_if` and contains the FSM and the APB output registers.

## Test plan

- Single write, `haddr`=0x8000_0001, `hwdata`=0x80 → `pselx`=001, `pwrite`=1, `paddr`=0x8000_0001, `pwdata`=0x80. `penable` is 0 in setup and 1 in the following cycle; FSM returns to IDLE.
- Single read, `haddr`=0x8000_0001, `prdata`=0x5A → READ then RENABLE, `pwrite`=0, `hrdata`=0x5A during RENABLE.
- 4-beat burst write, addresses 0x8000_0001–0x8000_0004 with random data → four APB writes in address order, each `pwdata` matching its beat, no dropped or duplicated beat.
- Decode at 0x8400_0010 → `pselx`=010; at 0x8800_0000 → `pselx`=100; at 0x9000_0000 → `pselx` stays 000 and the FSM stays in IDLE.
- `hresetn` pulsed low during WENABLEP of a burst → outputs at reset values within the same cycle; FSM in IDLE; a new single write after release completes normally.
